// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: hazard detection, EX operand forwarding and run/step/halt/drain
// control for the 5-stage MIPS pipeline.
// Optional feature macro: PIPE_CTRL_STALL_CNT_EN (builds the load-use stall counter).
module pipe_ctrl_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned DRAIN_DEPTH = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_loading,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_halt_instr,
  input  logic                  i_branch_taken,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_regwrite,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_pipe_en,
  output logic [2:0]            o_state,
  output logic                  o_halted,
  output logic [CNT_WIDTH-1:0]  o_cycle_count,
  output logic [CNT_WIDTH-1:0]  o_stall_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam int unsigned DRAIN_W = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_DEPTH - 1);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [DRAIN_W-1:0]   w_drain_nxt;
  logic [CNT_WIDTH-1:0] r_cycle_count;

  logic w_stall;
  logic w_load_entry;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_pipe_en;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Load-use hazard: a load in EX writes a register the ID instruction reads
  assign w_stall = i_ex_memread && (i_ex_rt != '0) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  // Operand A forwarding select, MEM has priority over WB, r0 never forwarded
  always_comb begin
    w_fwd_a = FWD_REG;
    if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs)) begin
      w_fwd_a = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs)) begin
      w_fwd_a = FWD_WB;
    end
  end

  // Operand B forwarding select, same priority rules on rt
  always_comb begin
    w_fwd_b = FWD_REG;
    if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rt)) begin
      w_fwd_b = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rt)) begin
      w_fwd_b = FWD_WB;
    end
  end

  // State and drain counter registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next-state and pipeline enable decode
  always_comb begin
    w_state_nxt   = r_state;
    w_drain_nxt   = r_drain_cnt;
    w_pc_en       = 1'b0;
    w_if_id_en    = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_pipe_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_loading) begin
          w_state_nxt = ST_LOAD;
        end else if (i_run) begin
          w_state_nxt = ST_RUN;
        end else if (i_step) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_LOAD: begin
        if (!i_loading) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        w_pipe_en = 1'b1;
        if (w_stall) begin
          w_id_ex_flush = 1'b1;
        end else begin
          w_pc_en       = !i_halt_instr;
          w_if_id_en    = 1'b1;
          w_if_id_flush = i_branch_taken;
        end
        if (i_halt_instr && !w_stall) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRAIN_INIT;
        end else if (r_state == ST_STEP) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_if_id_en    = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_pipe_en     = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        if (i_loading) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_load_entry = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);

  // Saturating count of cycles in which the back end advanced
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_count <= '0;
    end else if (w_load_entry) begin
      r_cycle_count <= '0;
    end else if (w_pipe_en && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic                 w_stall_inc;

  assign w_stall_inc = ((r_state == ST_RUN) || (r_state == ST_STEP)) && w_stall;

  // Saturating count of load-use bubbles inserted
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_count <= '0;
    end else if (w_load_entry) begin
      r_stall_count <= '0;
    end else if (w_stall_inc && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_WIDTH'(1);
    end
  end

  assign o_stall_count = r_stall_count;
`else
  assign o_stall_count = '0;
`endif

  assign o_fwd_a       = w_fwd_a;
  assign o_fwd_b       = w_fwd_b;
  assign o_pc_en       = w_pc_en;
  assign o_if_id_en    = w_if_id_en;
  assign o_if_id_flush = w_if_id_flush;
  assign o_id_ex_flush = w_id_ex_flush;
  assign o_pipe_en     = w_pipe_en;
  assign o_state       = r_state;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit.
module tb_pipe_ctrl_unit;

  logic        clk;
  logic        rst_n;
  logic        loading, run, step, halt_instr, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic        ex_memread, mem_regwrite, wb_regwrite;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_count, stall_count;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam int unsigned STALL_UNIT = 1;
`else
  localparam int unsigned STALL_UNIT = 0;
`endif

  pipe_ctrl_unit dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_loading      (loading),
    .i_run          (run),
    .i_step         (step),
    .i_halt_instr   (halt_instr),
    .i_branch_taken (branch_taken),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_rs        (ex_rs),
    .i_ex_rt        (ex_rt),
    .i_ex_memread   (ex_memread),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_pipe_en      (pipe_en),
    .o_state        (state),
    .o_halted       (halted),
    .o_cycle_count  (cycle_count),
    .o_stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // enables packed as {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}
  task automatic check_en(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    loading = 0; run = 0; step = 0; halt_instr = 0; branch_taken = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0;
    ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
    #2;
    check("rst_state", {29'd0, state}, 32'd0);
    check_en("rst_en", 5'b00000);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_stall", stall_count, 32'd0);

    // Forwarding is combinational, even while reset is held
    ex_rs = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
    #1 check("fwd_a_mem", {30'd0, fwd_a}, 32'd2);
    mem_regwrite = 0;
    #1 check("fwd_a_wb", {30'd0, fwd_a}, 32'd1);
    mem_regwrite = 1; ex_rs = 0; mem_rd = 0; wb_rd = 0;
    #1 check("fwd_a_r0", {30'd0, fwd_a}, 32'd0);
    ex_rt = 7; mem_rd = 7; wb_rd = 3;
    #1 check("fwd_b_mem", {30'd0, fwd_b}, 32'd2);
    mem_rd = 6; wb_rd = 7;
    #1 check("fwd_b_wb", {30'd0, fwd_b}, 32'd1);
    wb_regwrite = 0;
    #1 check("fwd_b_none", {30'd0, fwd_b}, 32'd0);
    ex_rt = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 0;
    rst_n = 1'b1;

    // Load for four clocks
    loading = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("load_state", {29'd0, state}, 32'd1);
    end
    check_en("load_en", 5'b00000);
    loading = 0;
    tick();
    check("load_exit", {29'd0, state}, 32'd0);
    check("load_cycle", cycle_count, 32'd0);

    // Single step with a taken branch
    step = 1; branch_taken = 1;
    #1 check_en("idle_en", 5'b00000);
    tick();
    step = 0;
    check("step_state", {29'd0, state}, 32'd3);
    check_en("step_en", 5'b11101);
    tick();
    check("step_done", {29'd0, state}, 32'd0);
    check("step_cycle", cycle_count, 32'd1);
    branch_taken = 0;

    // Run with load-use hazards
    run = 1;
    tick();
    check("run_state", {29'd0, state}, 32'd2);
    check_en("run_en", 5'b11001);
    ex_memread = 1; ex_rt = 8; id_rs = 8; branch_taken = 1;
    #1 check_en("stall_en", 5'b00011);
    tick();
    check("stall_cycle", cycle_count, 32'd2);
    check("stall_cnt1", stall_count, STALL_UNIT);
    ex_rt = 0; id_rs = 0;
    #1 check_en("r0_nostall", 5'b11101);
    branch_taken = 0;
    tick();
    check("nostall_cnt", stall_count, STALL_UNIT);
    ex_rt = 9; id_rt = 9;
    #1 check_en("stall_rt", 5'b00011);
    halt_instr = 1;
    tick();
    check("halt_stalled", {29'd0, state}, 32'd2);
    check("stall_cnt2", stall_count, 2 * STALL_UNIT);
    ex_memread = 0;
    #1 check_en("halt_en", 5'b01001);
    tick();
    halt_instr = 0;
    check("drain_state", {29'd0, state}, 32'd4);
    check("drain_cycle", cycle_count, 32'd5);
    for (int i = 0; i < 2; i++) begin
      check_en("drain_en", 5'b01111);
      tick();
      check("drain_hold", {29'd0, state}, 32'd4);
    end
    tick();
    check("halted_state", {29'd0, state}, 32'd5);
    check("halted_flag", {31'd0, halted}, 32'd1);
    check("halted_cycle", cycle_count, 32'd8);
    check_en("halted_en", 5'b00000);
    step = 1; halt_instr = 1;
    tick();
    check("halted_ignore", {29'd0, state}, 32'd5);
    step = 0; halt_instr = 0;
    loading = 1;
    tick();
    check("reload_state", {29'd0, state}, 32'd1);
    check("reload_cycle", cycle_count, 32'd0);
    check("reload_stall", stall_count, 32'd0);
    loading = 0; run = 0;
    tick();
    check("reload_idle", {29'd0, state}, 32'd0);

    // Asynchronous reset mid-run
    run = 1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("run_cycle7", cycle_count, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {29'd0, state}, 32'd0);
    check_en("arst_en", 5'b00000);
    check("arst_cycle", cycle_count, 32'd0);
    run = 0;
    rst_n = 1'b1;
    tick();
    check("post_rst", {29'd0, state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
